// File: rtl/wishbone_master_pkg.sv
// Shared Wishbone definitions: cycle-type identifiers, the master FSM state type
// and the helper that picks the cycle type for a latched command.
package wishbone_master_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_WAIT,
        ST_DONE
    } wb_state_e;

    // Single beats and tag_add reads are classic cycles; every beat of a longer
    // burst, including the last, is marked as an incrementing burst.
    function automatic logic [2:0] burst_cti(input logic [2:0] len, input logic tag_add);
        return (len == 3'd0 || tag_add) ? CTI_CLASSIC : CTI_INCR;
    endfunction

endpackage

// File: rtl/wishbone_master_if.sv
// Wishbone bus bundle between the burst master and a slave; signal names are
// taken from the master's point of view.
interface wishbone_master_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = DATA_WIDTH / 8
);
    logic                  cyc_o;
    logic                  stb_o;
    logic                  we_o;
    logic [ADDR_WIDTH-1:0] addr_o;
    logic [DATA_WIDTH-1:0] data_o;
    logic [SEL_WIDTH-1:0]  sel_o;
    logic [2:0]            cti_o;
    logic                  tag_add_o;
    logic                  ack_i;
    logic                  err_i;
    logic [DATA_WIDTH-1:0] data_i;

    modport master (
        output cyc_o, stb_o, we_o, addr_o, data_o, sel_o, cti_o, tag_add_o,
        input  ack_i, err_i, data_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, addr_o, data_o, sel_o, cti_o, tag_add_o,
        output ack_i, err_i, data_i
    );
endinterface

// File: rtl/wishbone_slave.sv
// Small Wishbone memory slave: DEPTH words, registered ack/err one cycle after each
// strobe, internal beat counter for incrementing bursts, tag_add returns mem[a]+mem[a+1].
module wishbone_slave
    import wishbone_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = DATA_WIDTH / 8,
    parameter int DEPTH      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ack_en_i,
    wishbone_master_if.slave bus
);

    localparam int IW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] beat_q;
    logic [ADDR_WIDTH-1:0] ea;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         idx_nx;
    logic                  hit;
    logic                  in_range;
    logic                  ack_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] dat_q;

    assign hit      = bus.cyc_o && bus.stb_o;
    assign ea       = bus.addr_o + beat_q;
    assign in_range = ea < ADDR_WIDTH'(DEPTH);
    assign idx      = ea[IW-1:0];
    assign idx_nx   = idx + 1'b1;

    assign bus.ack_i  = ack_q;
    assign bus.err_i  = err_q;
    assign bus.data_i = dat_q;

    // Beat counter restarts whenever the master drops cyc between commands.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            beat_q <= '0;
        end else begin
            ack_q <= hit && in_range && ack_en_i;
            err_q <= hit && !in_range && ack_en_i;
            if (!bus.cyc_o) begin
                beat_q <= '0;
            end else if (hit && bus.cti_o == CTI_INCR) begin
                beat_q <= beat_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (hit && !bus.we_o) begin
            dat_q <= bus.tag_add_o ? (mem[idx] + mem[idx_nx]) : mem[idx];
        end
        if (hit && bus.we_o && in_range) begin
            for (int b = 0; b < SEL_WIDTH; b++) begin
                if (bus.sel_o[b]) begin
                    mem[idx][b*8 +: 8] <= bus.data_o[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/wishbone_master.sv
// Command-driven Wishbone burst master: issues 1..8 beats at a fixed base address,
// tracks responses one cycle behind the strobes, and reports error/timeout/ack count.
module wishbone_master
    import wishbone_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [2:0]            cmd_len_i,
    input  logic [SEL_WIDTH-1:0]  cmd_sel_i,
    input  logic                  cmd_tag_add_i,
    input  logic                  wr_valid_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  wr_ready_o,
    output logic                  rd_valid_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  done_o,
    output logic                  err_flag_o,
    output logic                  timeout_o,
    output logic [3:0]            beats_ok_o,
    wishbone_master_if.master     bus
);

    localparam int TW = $clog2(TIMEOUT + 1);

    wb_state_e             state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            len_q, len_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic                  tag_add_q, tag_add_d;
    logic [3:0]            issued_q, issued_d;
    logic [3:0]            responded_q, responded_d;
    logic [3:0]            beats_ok_q, beats_ok_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  err_flag_q, err_flag_d;
    logic                  timeout_q, timeout_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic       in_cyc;
    logic       outstanding;
    logic       resp;
    logic       stb;
    logic       tmo_hit;
    logic [3:0] beats;

    assign beats       = {1'b0, len_q} + 4'd1;
    assign in_cyc      = (state_q == ST_BUS) || (state_q == ST_WAIT);
    assign outstanding = responded_q < issued_q;
    // Responses only count while a beat is actually owed, so stray acks are dropped.
    assign resp        = in_cyc && outstanding && (bus.ack_i || bus.err_i);
    assign stb         = (state_q == ST_BUS) && (issued_q < beats) && !bus.err_i
                         && !err_flag_q && (!we_q || wr_valid_i);
    assign tmo_hit     = in_cyc && outstanding && !resp && (tmo_q == TW'(TIMEOUT - 1));

    assign cmd_ready_o   = (state_q == ST_IDLE);
    assign wr_ready_o    = stb && we_q;
    assign rd_valid_o    = rd_valid_q;
    assign rd_data_o     = rd_data_q;
    assign done_o        = (state_q == ST_DONE);
    assign err_flag_o    = err_flag_q;
    assign timeout_o     = timeout_q;
    assign beats_ok_o    = beats_ok_q;

    assign bus.cyc_o     = in_cyc;
    assign bus.stb_o     = stb;
    assign bus.we_o      = in_cyc && we_q;
    assign bus.addr_o    = addr_q;
    assign bus.data_o    = wr_data_i;
    assign bus.sel_o     = sel_q;
    assign bus.cti_o     = in_cyc ? burst_cti(len_q, tag_add_q) : CTI_CLASSIC;
    assign bus.tag_add_o = in_cyc && tag_add_q;

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        len_d       = len_q;
        sel_d       = sel_q;
        tag_add_d   = tag_add_q;
        issued_d    = issued_q;
        responded_d = responded_q;
        beats_ok_d  = beats_ok_q;
        tmo_d       = tmo_q;
        err_flag_d  = err_flag_q;
        timeout_d   = timeout_q;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    // A tag_add command is always a single-beat read.
                    we_d        = cmd_we_i && !cmd_tag_add_i;
                    addr_d      = cmd_addr_i;
                    len_d       = cmd_tag_add_i ? 3'd0 : cmd_len_i;
                    sel_d       = cmd_sel_i;
                    tag_add_d   = cmd_tag_add_i;
                    issued_d    = 4'd0;
                    responded_d = 4'd0;
                    beats_ok_d  = 4'd0;
                    tmo_d       = '0;
                    err_flag_d  = 1'b0;
                    timeout_d   = 1'b0;
                    state_d     = ST_BUS;
                end
            end

            ST_BUS, ST_WAIT: begin
                if (stb) begin
                    issued_d = issued_q + 4'd1;
                end
                if (resp) begin
                    responded_d = responded_q + 4'd1;
                    tmo_d       = '0;
                    if (bus.ack_i) begin
                        beats_ok_d = beats_ok_q + 4'd1;
                        if (!we_q) begin
                            rd_valid_d = 1'b1;
                            rd_data_d  = bus.data_i;
                        end
                    end else begin
                        err_flag_d = 1'b1;
                    end
                end else if (outstanding) begin
                    tmo_d = tmo_q + 1'b1;
                end

                if (state_q == ST_BUS) begin
                    if ((resp && !bus.ack_i) || issued_d == beats) begin
                        state_d = ST_WAIT;
                    end
                end else if (responded_d == issued_q) begin
                    state_d = ST_DONE;
                end

                if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            len_q       <= 3'd0;
            sel_q       <= '0;
            tag_add_q   <= 1'b0;
            issued_q    <= 4'd0;
            responded_q <= 4'd0;
            beats_ok_q  <= 4'd0;
            tmo_q       <= '0;
            err_flag_q  <= 1'b0;
            timeout_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            sel_q       <= sel_d;
            tag_add_q   <= tag_add_d;
            issued_q    <= issued_d;
            responded_q <= responded_d;
            beats_ok_q  <= beats_ok_d;
            tmo_q       <= tmo_d;
            err_flag_q  <= err_flag_d;
            timeout_q   <= timeout_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_wishbone_master.sv
// Directed, table-driven bench for wishbone_master connected to wishbone_slave.
module tb_wishbone_master;
    import wishbone_master_pkg::*;

    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          ack_en;
    logic          cmd_valid, cmd_ready, cmd_we, cmd_tag_add;
    logic [AW-1:0] cmd_addr;
    logic [2:0]    cmd_len;
    logic [SW-1:0] cmd_sel;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          done, err_flag, timeout;
    logic [3:0]    beats_ok;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wishbone_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) bus ();

    wishbone_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_sel_i(cmd_sel),
        .cmd_tag_add_i(cmd_tag_add),
        .wr_valid_i(wr_valid), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
        .rd_valid_o(rd_valid), .rd_data_o(rd_data),
        .done_o(done), .err_flag_o(err_flag), .timeout_o(timeout), .beats_ok_o(beats_ok),
        .bus(bus)
    );

    wishbone_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .DEPTH(16)) slv (
        .clk_i(clk), .rst_i(rst), .ack_en_i(ack_en), .bus(bus)
    );

    typedef struct {
        logic            we;
        logic [AW-1:0]   addr;
        logic [2:0]      len;
        logic [SW-1:0]   sel;
        logic            tag;
        logic            ack_en;
        logic            stall;
        logic [3:0][31:0] wdata;
        int              exp_stb;
        int              exp_span;
        logic [2:0]      exp_cti;
        int              exp_rd_n;
        logic [3:0][31:0] exp_rd;
        logic            exp_err;
        logic            exp_to;
        logic [3:0]      exp_beats;
        int              exp_done_k;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic we, input logic [AW-1:0] addr, input logic [2:0] len,
                                input logic [SW-1:0] sel, input logic tag, input logic aen,
                                input logic stall, input logic [3:0][31:0] wd, input int n_stb,
                                input int span, input logic [2:0] cti, input int rd_n,
                                input logic [3:0][31:0] erd, input logic e_err, input logic e_to,
                                input logic [3:0] e_beats, input int done_k);
        vec_t v;
        v.we = we; v.addr = addr; v.len = len; v.sel = sel; v.tag = tag; v.ack_en = aen;
        v.stall = stall; v.wdata = wd; v.exp_stb = n_stb; v.exp_span = span; v.exp_cti = cti;
        v.exp_rd_n = rd_n; v.exp_rd = erd; v.exp_err = e_err; v.exp_to = e_to;
        v.exp_beats = e_beats; v.exp_done_k = done_k;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_and_check(input int id, input vec_t v);
        int n_stb = 0, first_stb = -1, last_stb = -1, cyc_low = 0;
        int cti_bad = 0, addr_bad = 0, tag_bad = 0, n_rd = 0, wbeat = 0, done_k = -1;
        logic [31:0] rd_buf [8];
        logic d_err = 1'b0, d_to = 1'b0;
        logic [3:0] d_beats = 4'd0;
        ack_en = v.ack_en;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = v.we; cmd_addr = v.addr; cmd_len = v.len;
        cmd_sel = v.sel; cmd_tag_add = v.tag; wr_valid = 1'b0;
        #1 chk($sformatf("v%0d_cmd_ready", id), 32'(cmd_ready), 32'd1);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            wr_valid  = v.we && !(v.stall && (k == 1 || k == 2));
            wr_data   = v.wdata[wbeat];
            #1;
            if (bus.stb_o) begin
                n_stb++;
                if (first_stb < 0) first_stb = k;
                last_stb = k;
                if (bus.cti_o !== v.exp_cti) cti_bad++;
                if (bus.addr_o !== v.addr) addr_bad++;
                if (bus.tag_add_o !== v.tag) tag_bad++;
            end else if (first_stb >= 0 && !bus.cyc_o && !done) begin
                cyc_low++;
            end
            if (wr_ready && wbeat < 3) wbeat++;
            if (rd_valid) begin
                if (n_rd < 8) rd_buf[n_rd] = rd_data;
                n_rd++;
            end
            if (done) begin
                done_k = k; d_err = err_flag; d_to = timeout; d_beats = beats_ok;
                break;
            end
        end
        wr_valid = 1'b0;
        $display("vec %0d we=%0b addr=%0d len=%0d stb=%0d rd=%0d err=%0b to=%0b beats=%0d done_k=%0d",
                 id, v.we, v.addr, v.len, n_stb, n_rd, d_err, d_to, d_beats, done_k);
        chk($sformatf("v%0d_done_k", id), 32'(done_k), 32'(v.exp_done_k));
        chk($sformatf("v%0d_n_stb", id), 32'(n_stb), 32'(v.exp_stb));
        chk($sformatf("v%0d_stb_span", id), 32'(last_stb - first_stb + 1), 32'(v.exp_span));
        chk($sformatf("v%0d_cyc_low", id), 32'(cyc_low), 32'd0);
        chk($sformatf("v%0d_cti_bad", id), 32'(cti_bad), 32'd0);
        chk($sformatf("v%0d_addr_bad", id), 32'(addr_bad), 32'd0);
        chk($sformatf("v%0d_tag_bad", id), 32'(tag_bad), 32'd0);
        chk($sformatf("v%0d_n_rd", id), 32'(n_rd), 32'(v.exp_rd_n));
        for (int i = 0; i < v.exp_rd_n && i < n_rd && i < 4; i++) begin
            chk($sformatf("v%0d_rd%0d", id, i), rd_buf[i], v.exp_rd[i]);
        end
        chk($sformatf("v%0d_err", id), 32'(d_err), 32'(v.exp_err));
        chk($sformatf("v%0d_timeout", id), 32'(d_to), 32'(v.exp_to));
        chk($sformatf("v%0d_beats_ok", id), 32'(d_beats), 32'(v.exp_beats));
        @(negedge clk);
        #1;
        chk($sformatf("v%0d_hold_err", id), 32'(err_flag), 32'(v.exp_err));
        chk($sformatf("v%0d_hold_to", id), 32'(timeout), 32'(v.exp_to));
        chk($sformatf("v%0d_hold_beats", id), 32'(beats_ok), 32'(v.exp_beats));
        chk($sformatf("v%0d_done_pulse", id), 32'(done), 32'd0);
        ack_en = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int d_cnt, c_cnt;
        logic [3:0][31:0] z;
        z = '0;
        //           we    addr   len   sel    tag   aen   stall wdata                                  stb span cti          rd erd                                        err   to    beats done_k
        vecs[0]  = mk(1'b1, 5'd3,  3'd0, 4'hF, 1'b0, 1'b1, 1'b0, {96'd0, 32'hDEADBEEF},                  1, 1, CTI_CLASSIC, 0, z,                                          1'b0, 1'b0, 4'd1, 2);
        vecs[1]  = mk(1'b0, 5'd3,  3'd0, 4'hF, 1'b0, 1'b1, 1'b0, z,                                      1, 1, CTI_CLASSIC, 1, {96'd0, 32'hDEADBEEF},                      1'b0, 1'b0, 4'd1, 2);
        vecs[2]  = mk(1'b1, 5'd4,  3'd3, 4'hF, 1'b0, 1'b1, 1'b0, {32'd4, 32'd3, 32'd2, 32'd1},           4, 4, CTI_INCR,    0, z,                                          1'b0, 1'b0, 4'd4, 5);
        vecs[3]  = mk(1'b0, 5'd4,  3'd3, 4'hF, 1'b0, 1'b1, 1'b0, z,                                      4, 4, CTI_INCR,    4, {32'd4, 32'd3, 32'd2, 32'd1},               1'b0, 1'b0, 4'd4, 5);
        vecs[4]  = mk(1'b1, 5'd14, 3'd3, 4'hF, 1'b0, 1'b1, 1'b0, {32'hD, 32'hC, 32'hB, 32'hA},           3, 3, CTI_INCR,    0, z,                                          1'b1, 1'b0, 4'd2, 5);
        vecs[5]  = mk(1'b0, 5'd14, 3'd1, 4'hF, 1'b0, 1'b1, 1'b0, z,                                      2, 2, CTI_INCR,    2, {64'd0, 32'hB, 32'hA},                      1'b0, 1'b0, 4'd2, 3);
        vecs[6]  = mk(1'b0, 5'd15, 3'd1, 4'hF, 1'b0, 1'b1, 1'b0, z,                                      2, 2, CTI_INCR,    1, {96'd0, 32'hB},                             1'b1, 1'b0, 4'd1, 3);
        vecs[7]  = mk(1'b1, 5'd0,  3'd1, 4'hF, 1'b0, 1'b1, 1'b0, {64'd0, 32'd7, 32'd5},                  2, 2, CTI_INCR,    0, z,                                          1'b0, 1'b0, 4'd2, 3);
        vecs[8]  = mk(1'b0, 5'd0,  3'd0, 4'hF, 1'b1, 1'b1, 1'b0, z,                                      1, 1, CTI_CLASSIC, 1, {96'd0, 32'd12},                            1'b0, 1'b0, 4'd1, 2);
        vecs[9]  = mk(1'b1, 5'd8,  3'd3, 4'hF, 1'b0, 1'b1, 1'b1, {32'h14, 32'h13, 32'h12, 32'h11},       4, 6, CTI_INCR,    0, z,                                          1'b0, 1'b0, 4'd4, 7);
        vecs[10] = mk(1'b0, 5'd8,  3'd3, 4'hF, 1'b0, 1'b1, 1'b0, z,                                      4, 4, CTI_INCR,    4, {32'h14, 32'h13, 32'h12, 32'h11},           1'b0, 1'b0, 4'd4, 5);
        vecs[11] = mk(1'b1, 5'd3,  3'd0, 4'h1, 1'b0, 1'b1, 1'b0, {96'd0, 32'h11223344},                  1, 1, CTI_CLASSIC, 0, z,                                          1'b0, 1'b0, 4'd1, 2);
        vecs[12] = mk(1'b0, 5'd3,  3'd0, 4'hF, 1'b0, 1'b1, 1'b0, z,                                      1, 1, CTI_CLASSIC, 1, {96'd0, 32'hDEADBE44},                      1'b0, 1'b0, 4'd1, 2);
        vecs[13] = mk(1'b0, 5'd0,  3'd3, 4'hF, 1'b0, 1'b0, 1'b0, z,                                      4, 4, CTI_INCR,    0, z,                                          1'b0, 1'b1, 4'd0, TMO + 1);

        rst = 1'b1; ack_en = 1'b1;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_sel = '0;
        cmd_tag_add = 1'b0; wr_valid = 1'b0; wr_data = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cyc", 32'(bus.cyc_o), 32'd0);
        chk("rst_stb", 32'(bus.stb_o), 32'd0);
        chk("rst_we", 32'(bus.we_o), 32'd0);
        chk("rst_cti", 32'(bus.cti_o), 32'd0);
        chk("rst_tag_add", 32'(bus.tag_add_o), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err_flag", 32'(err_flag), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_beats_ok", 32'(beats_ok), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_and_check(i, vecs[i]);
        end

        // Reset in the middle of a read burst: bus released at once, no completion.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 5'd4; cmd_len = 3'd7;
        cmd_sel = 4'hF; cmd_tag_add = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        #1 chk("mid_cyc_before", 32'(bus.cyc_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_cyc", 32'(bus.cyc_o), 32'd0);
        chk("mid_rst_stb", 32'(bus.stb_o), 32'd0);
        chk("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("mid_rst_beats_ok", 32'(beats_ok), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        d_cnt = 0; c_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            if (done) d_cnt++;
            if (bus.cyc_o) c_cnt++;
        end
        chk("mid_rst_no_done", 32'(d_cnt), 32'd0);
        chk("mid_rst_no_cyc", 32'(c_cnt), 32'd0);
        run_and_check(100, mk(1'b0, 5'd4, 3'd0, 4'hF, 1'b0, 1'b1, 1'b0, z, 1, 1, CTI_CLASSIC,
                              1, {96'd0, 32'd1}, 1'b0, 1'b0, 4'd1, 2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
